// File: rtl/picture_pkg.sv
// Shared types and helpers for the picture frame buffer: write FSM states,
// read latency, address sizing and the optional colour-bar pattern.
package picture_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } wr_state_t;

  localparam int unsigned READ_LATENCY = 3;

  function automatic int unsigned addr_width(input int unsigned h, input int unsigned v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

  function automatic logic [2:0] bar_index(input int unsigned h, input int unsigned h_size);
    return 3'(h * 8 / h_size);
  endfunction

  // Channel c is lit when bit (channels-1-c) of the bar index is set; only the
  // first three channels can ever be lit.
  function automatic logic chan_bar_on(input logic [2:0] bar, input int unsigned c,
                                       input int unsigned channels);
    if (c >= 3 || c >= channels || channels - 1 - c >= 3)
      return 1'b0;
    return bar[2'(channels - 1 - c)];
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port inferred RAM: one write port, one synchronous read-first
// read port, single clock.
module frame_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking write and read on the same edge give old data on a collision.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/picture_frame_buffer.sv
// Frame buffer: packs a byte stream into pixels, stores them, and serves a
// 3-cycle raster read port. Optional colour bars: FRAME_BUF_TEST_PATTERN_EN.
module picture_frame_buffer
  import picture_pkg::*;
#(
  parameter int unsigned H_SIZE   = 607,
  parameter int unsigned V_SIZE   = 455,
  parameter int unsigned CHAN_W   = 6,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned H_CNT_W  = 11,
  parameter int unsigned V_CNT_W  = 10,
  parameter logic [CHANNELS*CHAN_W-1:0] BORDER_RGB = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         reload,
  input  logic                         pix_en,
  input  logic [H_CNT_W-1:0]           h_count,
  input  logic [V_CNT_W-1:0]           v_count,
  output logic [CHANNELS*CHAN_W-1:0]   rgb,
  output logic                         rgb_valid,
  output logic                         loaded
);

  localparam int unsigned PIXEL_W = CHANNELS * CHAN_W;
  localparam int unsigned PIXELS  = H_SIZE * V_SIZE;
  localparam int unsigned AW      = addr_width(H_SIZE, V_SIZE);
  localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [7:0] s_data_unused;
  assign s_data_unused = s_data;

  wr_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [PIXEL_W-1:0]   shift_q, shift_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [PIXEL_W-1:0]   wr_data_q, wr_data_d;
  logic                 loaded_q, loaded_d;
  logic                 s_ready_q, s_ready_d;
  logic                 xfer, last_pix;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    loaded_d  = loaded_q;
    last_pix  = 1'b0;
    xfer      = s_valid && s_ready_q;
    if (reload) begin
      state_d  = LOAD;
      idx_d    = '0;
      addr_d   = '0;
      loaded_d = 1'b0;
    end else begin
      if (xfer) begin
        shift_d = (shift_q << CHAN_W) | PIXEL_W'(s_data[CHAN_W-1:0]);
        if (idx_q == IDX_W'(CHANNELS - 1)) begin
          idx_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = shift_d;
          addr_d    = addr_q + 1'b1;
          last_pix  = (addr_q == AW'(PIXELS - 1));
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if (wr_en_q && wr_addr_q == AW'(PIXELS - 1)) begin
        state_d  = DONE;
        loaded_d = 1'b1;
      end
    end
    // Stop accepting as soon as the final pixel is captured, not one cycle later.
    s_ready_d = (state_d == LOAD) && !last_pix;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      addr_q    <= '0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      loaded_q  <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      loaded_q  <= loaded_d;
      s_ready_q <= s_ready_d;
    end
  end

  logic               ram_we;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [PIXEL_W-1:0] ram_rdata;

  assign ram_we = wr_en_q && reset && !reload;

  frame_ram #(
    .DEPTH (PIXELS),
    .WIDTH (PIXEL_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  logic               in_win;
  logic               en1_q, win1_q, ld1_q;
  logic               en2_q, win2_q, ld2_q;
  logic [PIXEL_W-1:0] rgb_q, rgb_d;
  logic               rgb_valid_q, rgb_valid_d;

`ifdef FRAME_BUF_TEST_PATTERN_EN
  logic [PIXEL_W-1:0] pat_d, pat1_q, pat2_q;
  logic [2:0]         bar;

  always_comb begin
    pat_d = '0;
    bar   = bar_index(32'(h_count), H_SIZE);
    for (int unsigned c = 0; c < CHANNELS; c++)
      if (chan_bar_on(bar, c, CHANNELS))
        pat_d[(CHANNELS-1-c)*CHAN_W +: CHAN_W] = '1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat1_q <= '0;
      pat2_q <= '0;
    end else begin
      pat1_q <= pat_d;
      pat2_q <= pat1_q;
    end
  end
`endif

  always_comb begin
    in_win      = (32'(h_count) < H_SIZE) && (32'(v_count) < V_SIZE);
    rd_addr_d   = in_win ? AW'(32'(v_count) * H_SIZE + 32'(h_count)) : '0;
    rgb_valid_d = en2_q;
    rgb_d       = BORDER_RGB;
    if (en2_q && win2_q && ld2_q)
      rgb_d = ram_rdata;
`ifdef FRAME_BUF_TEST_PATTERN_EN
    else if (en2_q && win2_q)
      rgb_d = pat2_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en1_q       <= 1'b0;
      win1_q      <= 1'b0;
      ld1_q       <= 1'b0;
      rd_addr_q   <= '0;
      en2_q       <= 1'b0;
      win2_q      <= 1'b0;
      ld2_q       <= 1'b0;
      rgb_q       <= BORDER_RGB;
      rgb_valid_q <= 1'b0;
    end else begin
      en1_q       <= pix_en;
      win1_q      <= in_win;
      ld1_q       <= loaded_q;
      rd_addr_q   <= rd_addr_d;
      en2_q       <= en1_q;
      win2_q      <= win1_q;
      ld2_q       <= ld1_q;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign loaded    = loaded_q;
  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_picture_frame_buffer.sv
// Self-checking bench for picture_frame_buffer on a 4x3 image with 6-bit
// channels; honours FRAME_BUF_TEST_PATTERN_EN when defined.
module tb_picture_frame_buffer;
  import picture_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned CW = 6;
  localparam int unsigned CH = 3;
  localparam int unsigned PW = CH * CW;
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam logic [PW-1:0] BORDER = 18'h2A5A5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          reload = 1'b0;
  logic          pix_en = 1'b0;
  logic [HW-1:0] h_count = '0;
  logic [VW-1:0] v_count = '0;
  logic [PW-1:0] rgb;
  logic          rgb_valid;
  logic          loaded;

  always #5 clk = ~clk;

  picture_frame_buffer #(
    .H_SIZE     (H),
    .V_SIZE     (V),
    .CHAN_W     (CW),
    .CHANNELS   (CH),
    .H_CNT_W    (HW),
    .V_CNT_W    (VW),
    .BORDER_RGB (BORDER)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .reload    (reload),
    .pix_en    (pix_en),
    .h_count   (h_count),
    .v_count   (v_count),
    .rgb       (rgb),
    .rgb_valid (rgb_valid),
    .loaded    (loaded)
  );

  logic          fr_we = 1'b0;
  logic [3:0]    fr_waddr = '0;
  logic [3:0]    fr_raddr = '0;
  logic [PW-1:0] fr_wdata = '0;
  logic [PW-1:0] fr_rdata;

  frame_ram #(.DEPTH(H * V), .WIDTH(PW)) u_fr (
    .clk   (clk),
    .we    (fr_we),
    .waddr (fr_waddr),
    .wdata (fr_wdata),
    .raddr (fr_raddr),
    .rdata (fr_rdata)
  );

  typedef struct {
    logic          en;
    int unsigned   h;
    int unsigned   v;
    logic          exp_valid;
    logic [PW-1:0] exp_rgb;
  } vec_t;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  logic [PW-1:0] m_img [H*V];
  logic          m_loaded = 1'b0;
  logic [CW-1:0] tx_q [$];
  vec_t          vecs [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pattern_px(input int unsigned h);
`ifdef FRAME_BUF_TEST_PATTERN_EN
    logic [2:0] idx;
    idx = 3'(h * 8 / H);
    return {idx[2] ? 6'h3F : 6'h00, idx[1] ? 6'h3F : 6'h00, idx[0] ? 6'h3F : 6'h00};
`else
    return BORDER;
`endif
  endfunction

  function automatic logic [PW-1:0] model_read(input logic en, input int unsigned h,
                                               input int unsigned v);
    if (!en || h >= H || v >= V) return BORDER;
    if (m_loaded) return m_img[v * H + h];
    return pattern_px(h);
  endfunction

  function automatic vec_t mk_vec(input logic en, input int unsigned h, input int unsigned v);
    vec_t r;
    r.en = en; r.h = h; r.v = v;
    r.exp_valid = en;
    r.exp_rgb = model_read(en, h, v);
    return r;
  endfunction

  task automatic run_vecs();
    int unsigned n = vecs.size();
    for (int unsigned i = 0; i < n + READ_LATENCY - 1; i++) begin
      if (i < n) begin
        pix_en  = vecs[i].en;
        h_count = HW'(vecs[i].h);
        v_count = VW'(vecs[i].v);
      end else begin
        pix_en = 1'b0;
      end
      tick();
      if (i >= READ_LATENCY - 1) begin
        check("rgb_valid", 32'(rgb_valid), 32'(vecs[i-READ_LATENCY+1].exp_valid));
        check("rgb", 32'(rgb), 32'(vecs[i-READ_LATENCY+1].exp_rgb));
      end
    end
    vecs.delete();
  endtask

  task automatic sweep_and_random(input int unsigned nrand);
    for (int unsigned v = 0; v <= V; v++)
      for (int unsigned h = 0; h <= H + 1; h++)
        vecs.push_back(mk_vec(1'b1, h, v));
    vecs.push_back(mk_vec(1'b1, 2047, 0));
    vecs.push_back(mk_vec(1'b1, 0, 1023));
    vecs.push_back(mk_vec(1'b0, 1, 1));
    for (int unsigned i = 0; i < nrand; i++)
      vecs.push_back(mk_vec($urandom_range(0, 3) != 0, $urandom_range(0, H + 1),
                            $urandom_range(0, V)));
    run_vecs();
  endtask

  task automatic send_byte(input logic [CW-1:0] b, input int unsigned max_gap);
    int unsigned guard = 0;
    s_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) tick();
    s_data  = {2'($urandom), b};
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("s_ready_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // Streams tx_q as a full image and updates the reference image from it.
  task automatic load_image();
    for (int unsigned i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], 3);
      if (i == tx_q.size() / 2) check("loaded_mid_fill", 32'(loaded), 32'd0);
    end
    check("loaded_at_last_byte", 32'(loaded), 32'd0);
    check("s_ready_at_last_byte", 32'(s_ready), 32'd0);
    tick();
    check("loaded_rise", 32'(loaded), 32'd1);
    check("s_ready_done", 32'(s_ready), 32'd0);
    for (int unsigned k = 0; k < H * V; k++)
      m_img[k] = {tx_q[3*k], tx_q[3*k+1], tx_q[3*k+2]};
    m_loaded = 1'b1;
  endtask

  task automatic fill_ramp();
    tx_q.delete();
    for (int unsigned k = 0; k < H * V; k++) begin
      tx_q.push_back(CW'(k));
      tx_q.push_back(CW'(k + 1));
      tx_q.push_back(CW'(k + 2));
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("reset_loaded", 32'(loaded), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
    check("reset_rgb", 32'(rgb), 32'(BORDER));
    reset = 1'b1;
    tick();
    check("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Unloaded reads: border or colour bars
    sweep_and_random(4);

    // Ramp image with random gaps, then an extra byte that must be refused
    fill_ramp();
    load_image();
    s_valid = 1'b1;
    s_data  = 8'h15;
    repeat (4) tick();
    check("extra_byte_s_ready", 32'(s_ready), 32'd0);
    check("extra_byte_loaded", 32'(loaded), 32'd1);
    s_valid = 1'b0;
    sweep_and_random(40);

    // Reload, partial pixel, reload coinciding with a byte, then a new image
    reload = 1'b1;
    tick();
    reload = 1'b0;
    m_loaded = 1'b0;
    check("reload_loaded", 32'(loaded), 32'd0);
    check("reload_s_ready", 32'(s_ready), 32'd1);
    for (int unsigned i = 0; i < 5; i++) send_byte(CW'($urandom), 2);
    s_data  = 8'h3F;
    s_valid = 1'b1;
    reload  = 1'b1;
    tick();
    reload  = 1'b0;
    s_valid = 1'b0;
    check("reload2_loaded", 32'(loaded), 32'd0);
    tx_q.delete();
    for (int unsigned i = 0; i < 3 * H * V; i++) tx_q.push_back(CW'($urandom));
    load_image();
    sweep_and_random(40);

    // Reset in the middle of a read stream
    pix_en  = 1'b1;
    h_count = 11'd1;
    v_count = 10'd1;
    repeat (3) tick();
    check("pre_reset_valid", 32'(rgb_valid), 32'd1);
    check("pre_reset_rgb", 32'(rgb), 32'(m_img[5]));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_loaded = 1'b0;
    check("post_reset_loaded", 32'(loaded), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      check("post_reset_valid", 32'(rgb_valid), 32'd0);
      check("post_reset_rgb", 32'(rgb), 32'(BORDER));
      tick();
    end
    check("post_reset_valid_back", 32'(rgb_valid), 32'd1);
    check("post_reset_rgb_masked", 32'(rgb), 32'(model_read(1'b1, 1, 1)));
    pix_en = 1'b0;
    sweep_and_random(8);

    // Refill after reset
    fill_ramp();
    load_image();
    sweep_and_random(20);

    // Read-first collision on the RAM primitive
    fr_we = 1'b1; fr_waddr = 4'd5; fr_raddr = 4'd5; fr_wdata = 18'h11111;
    tick();
    fr_wdata = 18'h22222;
    tick();
    check("ram_read_first_old", 32'(fr_rdata), 32'h11111);
    fr_we = 1'b0;
    tick();
    check("ram_read_after_write", 32'(fr_rdata), 32'h22222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
